// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- instruction fetch stage of the riscv_core pipeline.
//
// Owns the architectural fetch PC and issues one read per cycle to a
// synchronous-read instruction memory (1-cycle latency). The word returned by
// memory is paired with the PC of the request that produced it and handed to
// decode. A one-entry hold buffer absorbs decode stalls, and redirects from
// later stages cost a single squashed bubble.
//
// Handshake: there is no ready signal toward decode. valid_o=1 means
// inst_o/pc_o carry a real instruction; decode consumes it on any cycle where
// stall_i=0. While stall_i=1 (and no redirect) the outputs are held constant.
//
// Ports:
//   clk            core clock
//   rst            synchronous, active-high reset
//   stall_i        decode/hazard stall: hold current output, issue no fetch
//   redirect_i     taken branch/jump: squash output, refetch redirect_pc_i
//   redirect_pc_i  redirect target (passed through unchanged)
//   imem_en_o      instruction memory read enable
//   imem_addr_o    instruction memory byte address (combinational)
//   imem_rdata_i   data for the address of the previous enabled cycle
//   inst_o         instruction to decode (NOP_INST when not valid)
//   pc_o           PC of inst_o
//   valid_o        inst_o/pc_o are a real instruction
// -----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_en_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  logic [31:0] fetch_pc;
  logic        req_valid_q;
  logic [31:0] req_pc_q;
  logic        hold_valid_q;
  logic [31:0] hold_inst_q;

  // A redirect always fetches, even under stall: the stalled instruction is
  // dropped in favour of the new path.
  assign imem_en_o   = !rst && (!stall_i || redirect_i);
  assign imem_addr_o = redirect_i ? redirect_pc_i : fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      req_valid_q  <= 1'b0;
      req_pc_q     <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_inst_q  <= NOP_INST;
    end else begin
      if (imem_en_o) begin
        fetch_pc    <= imem_addr_o + 32'd4;
        req_pc_q    <= imem_addr_o;
        req_valid_q <= 1'b1;
      end

      // Memory data is only guaranteed on the cycle right after the read, so
      // capture it on the first stall cycle and serve from the buffer until
      // the stall releases.
      if (redirect_i || !stall_i) begin
        hold_valid_q <= 1'b0;
      end else if (req_valid_q && !hold_valid_q) begin
        hold_valid_q <= 1'b1;
        hold_inst_q  <= imem_rdata_i;
      end
    end
  end

  always_comb begin
    valid_o = req_valid_q && !redirect_i && !rst;
    pc_o    = rst ? RESET_PC : req_pc_q;
    if (!valid_o) begin
      inst_o = NOP_INST;
    end else if (hold_valid_q) begin
      inst_o = hold_inst_q;
    end else begin
      inst_o = imem_rdata_i;
    end
  end

endmodule
